systolic_seq_ctrl: RTL and testbench

- Sequencer for the NxN output-stationary systolic_array.
- On a start pulse it runs four steps: clear the array accumulators, load N weight rows from weight memory onto weightin (bottom row first), stream num_vec activation vectors from data memory onto datain with per-lane diagonal skew, then wait out the pipeline drain and pulse done.
- Sits between the on-chip operand buffers and systolic_array.

---
 rtl/systolic_seq_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: job sequencer for an NxN output-stationary systolic array.
// A job clears the accumulators, loads N weight rows (bottom row first),
// streams num_vec activation vectors with per-lane diagonal skew, then
// waits out the array drain and pulses done.
// Optional feature macro: SYSTOLIC_WREUSE_EN (adds reuse_w to skip the weight
// load when the array already holds weights from an earlier job).
module systolic_seq_ctrl #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int DRAIN_CYC = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           num_vec,
`ifdef SYSTOLIC_WREUSE_EN
  input  logic                 reuse_w,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 array_clr,
  output logic                 w_rd_en,
  output logic [$clog2(N)-1:0] w_rd_addr,
  input  logic [N*DW-1:0]      w_rd_data,
  output logic                 d_rd_en,
  output logic [7:0]           d_rd_addr,
  input  logic [N*DW-1:0]      d_rd_data,
  output logic [N*DW-1:0]      weightin,
  output logic                 weight_load,
  output logic [N*DW-1:0]      datain
);

  localparam int AW = $clog2(N);
  // One counter serves WLOAD, STREAM and DRAIN; it must hold 0..254 and
  // 0..DRAIN_CYC-1.
  localparam int CW = ($clog2(DRAIN_CYC + 1) > 8) ? $clog2(DRAIN_CYC + 1) : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      nv_q, nv_d;
  logic            reuse_q, reuse_d;
  logic            have_w_q, have_w_d;
  logic            reuse_req;

`ifdef SYSTOLIC_WREUSE_EN
  assign reuse_req = reuse_w;
`else
  assign reuse_req = 1'b0;
`endif

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      nv_q     <= '0;
      reuse_q  <= 1'b0;
      have_w_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nv_q     <= nv_d;
      reuse_q  <= reuse_d;
      have_w_q <= have_w_d;
    end
  end

  // Next-state and memory-request decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nv_d      = nv_q;
    reuse_d   = reuse_q;
    have_w_d  = have_w_q;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    array_clr = 1'b0;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    d_rd_en   = 1'b0;
    d_rd_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nv_d    = num_vec;
          // Reuse is only honoured once a full weight load has completed.
          reuse_d = reuse_req & have_w_q;
          cnt_d   = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        array_clr = 1'b1;
        cnt_d     = '0;
        if (reuse_q) begin
          state_d = (nv_q == 8'd0) ? S_DRAIN : S_STREAM;
        end else begin
          state_d = S_WLOAD;
        end
      end
      S_WLOAD: begin
        w_rd_en   = 1'b1;
        w_rd_addr = AW'(N - 1) - cnt_q[AW-1:0];
        if (cnt_q == CW'(N - 1)) begin
          cnt_d    = '0;
          have_w_d = 1'b1;
          state_d  = (nv_q == 8'd0) ? S_DRAIN : S_STREAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        d_rd_en   = 1'b1;
        d_rd_addr = cnt_q[7:0];
        // Compare against count+1 so num_vec=255 ends at address 254
        // without the counter wrapping.
        if ((cnt_q + 1'b1) == CW'(nv_q)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Weight path: read data arrives one cycle after w_rd_en, then registered
  logic            w_vld_q;
  logic [N*DW-1:0] weightin_q;
  logic            weight_load_q;

  // Delay read enable and register the returned row (zero when not valid)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_vld_q       <= 1'b0;
      weight_load_q <= 1'b0;
      weightin_q    <= '0;
    end else begin
      w_vld_q       <= w_rd_en;
      weight_load_q <= w_vld_q;
      weightin_q    <= w_vld_q ? w_rd_data : '0;
    end
  end

  assign weightin    = weightin_q;
  assign weight_load = weight_load_q;

  // Activation path: gate unused slots to zero, then skew lane k by k cycles
  logic            d_vld_q;
  logic [N*DW-1:0] skew_in;

  // Track which cycles carry valid activation data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_vld_q <= 1'b0;
    end else begin
      d_vld_q <= d_rd_en;
    end
  end

  assign skew_in = d_vld_q ? d_rd_data : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DW-1:0] lane_q;
      if (gi == 0) begin : g_direct
        // Lane 0 has no skew stages, only the output register
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            lane_q <= '0;
          end else begin
            lane_q <= skew_in[0 +: DW];
          end
        end
      end else begin : g_skew
        logic [DW-1:0] sr_q [gi];
        // Shift every cycle regardless of state so zeros flush the chain
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            for (int j = 0; j < gi; j++) begin
              sr_q[j] <= '0;
            end
            lane_q <= '0;
          end else begin
            sr_q[0] <= skew_in[gi*DW +: DW];
            for (int j = 1; j < gi; j++) begin
              sr_q[j] <= sr_q[j-1];
            end
            lane_q <= sr_q[gi-1];
          end
        end
      end
      assign datain[gi*DW +: DW] = lane_q;
    end
  endgenerate

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: a cycle-table model derived from job timing
// rules is compared against every output on each falling edge, and a set of
// literal expectations from hand-worked jobs pins that model.
module tb_systolic_seq_ctrl;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DRAIN = 12;
  localparam int AW    = 2;
  localparam int WW    = N * DW;

  logic          clk;
  logic          reset;
  logic          start;
  logic          reuse_w;
  logic [7:0]    num_vec;
  logic          busy, done, array_clr, w_rd_en, d_rd_en, weight_load;
  logic [AW-1:0] w_rd_addr;
  logic [7:0]    d_rd_addr;
  logic [WW-1:0] w_rd_data, d_rd_data, weightin, datain;

  logic [WW-1:0] wmem [N];
  logic [WW-1:0] dmem [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_total = 0;
  bit chk_en = 0;

  systolic_seq_ctrl #(.N(N), .DW(DW), .DRAIN_CYC(DRAIN)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_vec     (num_vec),
`ifdef SYSTOLIC_WREUSE_EN
    .reuse_w     (reuse_w),
`endif
    .busy        (busy),
    .done        (done),
    .array_clr   (array_clr),
    .w_rd_en     (w_rd_en),
    .w_rd_addr   (w_rd_addr),
    .w_rd_data   (w_rd_data),
    .d_rd_en     (d_rd_en),
    .d_rd_addr   (d_rd_addr),
    .d_rd_data   (d_rd_data),
    .weightin    (weightin),
    .weight_load (weight_load),
    .datain      (datain)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Memories: registered read; garbage when not enabled so gating is exercised
  always @(posedge clk) begin
    w_rd_data <= w_rd_en ? wmem[w_rd_addr] : 32'hDEADBEEF;
    d_rd_data <= d_rd_en ? dmem[d_rd_addr] : 32'hBADC0FFE;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model state
  bit in_job = 0;
  bit wloaded = 0;
  int js, jnv, jwl;
  // Per-job records of DUT behaviour, indexed by cycle relative to start
  logic [WW-1:0] rec_din  [64];
  logic [WW-1:0] rec_win  [64];
  logic [AW-1:0] rec_waddr[64];
  int rec_wen_cnt, rec_den_cnt, rec_wl_cnt, rec_max_daddr;
  int rec_first_den, rec_done_rel, rec_clr_rel;

  always @(negedge clk) begin : mon
    int r, last, idx;
    bit accept;
    logic e_busy, e_done, e_clr, e_wen, e_den, e_wl;
    logic [AW-1:0] e_waddr;
    logic [7:0] e_daddr;
    logic [WW-1:0] e_win, e_din;
    if (chk_en) begin
      e_busy = 0; e_done = 0; e_clr = 0; e_wen = 0; e_den = 0; e_wl = 0;
      e_waddr = '0; e_daddr = '0; e_win = '0; e_din = '0;
      r = 0; last = 0;
      if (reset && in_job) begin
        r = cyc - js;
        last = 2 + jwl + jnv + DRAIN;
        e_busy = (r >= 1) && (r <= last);
        e_done = (r == last);
        e_clr  = (r == 1);
        if (r >= 2 && r < 2 + jwl) begin
          e_wen = 1;
          e_waddr = AW'(N - 1 - (r - 2));
        end
        if (r >= 4 && r < 4 + jwl) begin
          e_wl = 1;
          e_win = wmem[N - 1 - (r - 4)];
        end
        if (r >= 2 + jwl && r < 2 + jwl + jnv) begin
          e_den = 1;
          e_daddr = 8'(r - 2 - jwl);
        end
        for (int k = 0; k < N; k++) begin
          idx = r - 4 - jwl - k;
          if (idx >= 0 && idx < jnv) e_din[k*DW +: DW] = dmem[idx][k*DW +: DW];
        end
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("array_clr", array_clr, e_clr);
      chk("w_rd_en", w_rd_en, e_wen);
      if (e_wen) chk("w_rd_addr", w_rd_addr, e_waddr);
      chk("d_rd_en", d_rd_en, e_den);
      if (e_den) chk("d_rd_addr", d_rd_addr, e_daddr);
      chk("weight_load", weight_load, e_wl);
      chk("weightin", weightin, e_win);
      chk("datain", datain, e_din);

      if (reset && in_job) begin
        if (r < 64) begin
          rec_din[r] = datain;
          rec_win[r] = weightin;
          rec_waddr[r] = w_rd_addr;
        end
        if (w_rd_en) rec_wen_cnt++;
        if (weight_load) rec_wl_cnt++;
        if (d_rd_en) begin
          rec_den_cnt++;
          if (rec_first_den < 0) rec_first_den = r;
          if (int'(d_rd_addr) > rec_max_daddr) rec_max_daddr = int'(d_rd_addr);
        end
        if (done) rec_done_rel = r;
        if (array_clr) rec_clr_rel = r;
      end
      if (done === 1'b1) done_total++;

      accept = reset && start && !in_job;
      if (!reset) begin
        in_job = 0;
        wloaded = 0;
      end else if (in_job) begin
        if (jwl == N && r == 1 + N) wloaded = 1;
        if (r >= last) in_job = 0;
      end
      if (accept) begin
`ifdef SYSTOLIC_WREUSE_EN
        jwl = (reuse_w && wloaded) ? 0 : N;
`else
        jwl = N;
`endif
        in_job = 1;
        js = cyc;
        jnv = int'(num_vec);
        rec_wen_cnt = 0; rec_den_cnt = 0; rec_wl_cnt = 0; rec_max_daddr = -1;
        rec_first_den = -1; rec_done_rel = -1; rec_clr_rel = -1;
        for (int i = 0; i < 64; i++) begin
          rec_din[i] = '0;
          rec_win[i] = '0;
          rec_waddr[i] = '0;
        end
      end
    end
  end

  task automatic go(input int nv, input bit ru);
    @(posedge clk); #1;
    start = 1'b1; num_vec = 8'(nv); reuse_w = ru;
    @(posedge clk); #1;
    start = 1'b0; num_vec = 8'hAA; reuse_w = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string nm);
    int n;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      if (done === 1'b1) break;
      n++;
    end
    chk({"timeout_", nm}, 64'(n < limit), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0;
    reset = 1'b1; start = 1'b0; num_vec = 8'd0; reuse_w = 1'b0;
    wmem[0] = 32'h01010101; wmem[1] = 32'h02020202;
    wmem[2] = 32'h03030303; wmem[3] = 32'h04040404;
    for (int a = 0; a < 256; a++) begin
      dmem[a] = {8'(a) ^ 8'h3C, ~8'(a), 8'(a) + 8'd7, 8'(a)};
    end
    dmem[0] = 32'h00000401; dmem[1] = 32'h00000502; dmem[2] = 32'h00000603;

    // Reset state
    #2 reset = 1'b0; chk_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_datain", datain, 0);
    chk("rst_weightin", weightin, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Job with num_vec=3: weight load order, skew and done timing
    go(3, 1'b0);
    wait_done(100, "job3");
    chk("j3_clr_rel", rec_clr_rel, 1);
    chk("j3_waddr2", rec_waddr[2], 3);
    chk("j3_waddr5", rec_waddr[5], 0);
    chk("j3_win4", rec_win[4], 32'h04040404);
    chk("j3_win5", rec_win[5], 32'h03030303);
    chk("j3_win7", rec_win[7], 32'h01010101);
    chk("j3_win8", rec_win[8], 0);
    chk("j3_wl_cnt", rec_wl_cnt, 4);
    chk("j3_first_den", rec_first_den, 6);
    chk("j3_lane0_c8", rec_din[8][7:0], 8'h01);
    chk("j3_lane0_c10", rec_din[10][7:0], 8'h03);
    chk("j3_lane1_c8", rec_din[8][15:8], 8'h00);
    chk("j3_lane1_c9", rec_din[9][15:8], 8'h04);
    chk("j3_lane1_c11", rec_din[11][15:8], 8'h06);
    chk("j3_lane0_c11", rec_din[11][7:0], 8'h00);
    chk("j3_upper_c10", rec_din[10][31:16], 16'h0000);
    chk("j3_done_rel", rec_done_rel, 21);

    // num_vec=0: weight load only, no data reads
    go(0, 1'b0);
    wait_done(100, "job0");
    chk("j0_den_cnt", rec_den_cnt, 0);
    chk("j0_wen_cnt", rec_wen_cnt, 4);
    chk("j0_done_rel", rec_done_rel, 18);

    // Starts while busy and in the DONE cycle are ignored
    d0 = done_total;
    go(5, 1'b0);
    repeat (6) @(posedge clk);
    #1 start = 1'b1; num_vec = 8'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 start = 1'b1; num_vec = 8'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(posedge clk);
    chk("j5_done_pulses", done_total - d0, 1);
    chk("j5_den_cnt", rec_den_cnt, 5);
    chk("j5_max_daddr", rec_max_daddr, 4);
    chk("j5_done_rel", rec_done_rel, 23);

    // num_vec=255: no counter wrap
    go(255, 1'b0);
    wait_done(400, "job255");
    chk("j255_den_cnt", rec_den_cnt, 255);
    chk("j255_max_daddr", rec_max_daddr, 254);
    chk("j255_done_rel", rec_done_rel, 273);

    // Reset during STREAM at v=2 aborts the job
    go(6, 1'b0);
    repeat (7) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_datain", datain, 0);
    chk("abort_weightin", weightin, 0);
    chk("abort_d_rd_en", d_rd_en, 0);
    @(posedge clk); #1 reset = 1'b1;
    d0 = done_total;
    repeat (30) @(posedge clk);
    chk("abort_no_done", done_total - d0, 0);
    go(1, 1'b0);
    wait_done(100, "after_abort");
    chk("ab1_den_cnt", rec_den_cnt, 1);
    chk("ab1_done_rel", rec_done_rel, 19);

`ifdef SYSTOLIC_WREUSE_EN
    // Weight reuse: ignored on first job after reset, honoured afterwards
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    go(2, 1'b1);
    wait_done(100, "reuse_first");
    chk("ru1_wen_cnt", rec_wen_cnt, 4);
    chk("ru1_done_rel", rec_done_rel, 20);
    go(2, 1'b1);
    wait_done(100, "reuse_second");
    chk("ru2_wen_cnt", rec_wen_cnt, 0);
    chk("ru2_wl_cnt", rec_wl_cnt, 0);
    chk("ru2_first_den", rec_first_den, 2);
    chk("ru2_done_rel", rec_done_rel, 16);
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
